reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Multi-channel reset controller that merges CHANNELS asynchronous active-low reset requests and drives CHANNELS active-high reset outputs. All outputs assert together. They release in a fixed order (channel 0 first), after a quiet hold period and with a programmable step between channels. It sits at the top of each clock domain and replaces per-domain single-bit reset synchronisers where several sub-blocks must leave reset in order, e.g. PLL/PHY, then link layer, then user logic.

## Interface
- CHANNELS, 4: number of request inputs and reset outputs; 1..16.
- STAGES, 2: synchroniser depth per request; values below 2 are clamped to 2.
- HOLD_CYCLES, 16: quiet cycles required before channel 0 releases; ≥1.
- STEP_CYCLES, 4: cycles between release of channel k and channel k+1; ≥1.
- FILTER_CYCLES, 3: minimum synced assertion length; used only with RST_SEQ_FILTER_EN; ≥1.
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_n  in  CHANNELS  asynchronous reset requests, active-low.
- o_rst  out  CHANNELS  reset outputs, active-high, registered.
- o_busy  out  1  high while any o_rst bit is high.
- o_cause  out  CHANNELS  request vector that triggered the last sequence, plus any request seen before release completed.

## Operation
- Each i_req_n bit passes through its own STAGES-flop synchroniser. Synced active request vector: req_s. r_any = |req_s.
- While i_rst_n is low, at each edge:
  - synchroniser flops load "request active";
  - o_rst = all ones, o_busy = 1, o_cause = 0;
  - state = ASSERT, counter = 0, index = 0.
- FSM states:
  - ASSERT: o_rst all ones. If !r_any, go to HOLD and load counter with HOLD_CYCLES-1.
  - HOLD: if r_any, go to ASSERT. Otherwise decrement the counter. At 0, clear o_rst[0]. If CHANNELS==1, go to DONE. Otherwise go to RELEASE with index=1 and counter=STEP_CYCLES-1.
  - RELEASE: if r_any, go to ASSERT and set all o_rst bits again. Otherwise decrement the counter. At 0, clear o_rst[index]. If index==CHANNELS-1, go to DONE. Otherwise increment index and reload STEP_CYCLES-1.
  - DONE: o_busy = 0. If r_any, go to ASSERT.
- o_rst is always a thermometer pattern: o_rst[k]==0 implies o_rst[j]==0 for all j<k.
- o_cause:
  - loaded with req_s on DONE→ASSERT;
  - OR-accumulates req_s while in ASSERT, HOLD or RELEASE;
  - holds its value in DONE.
- Counter width is clog2(max(HOLD_CYCLES, STEP_CYCLES)), minimum 1. The counter never wraps.

## Timing
- Edge numbering: a request sampled low at edge 0 reaches the last synchroniser flop at edge STAGES-1.
- Assertion:
  - state = ASSERT and o_rst = all ones after edge STAGES;
  - o_busy rises at the same edge.
- Release, with the request sampled high at edge 0:
  - HOLD is entered at edge STAGES;
  - o_rst[0] falls at edge STAGES+HOLD_CYCLES;
  - o_rst[k] falls at edge STAGES+HOLD_CYCLES+k·STEP_CYCLES;
  - o_busy falls with the last channel.
- A request during HOLD or RELEASE re-asserts all outputs STAGES edges after sampling, and the full sequence restarts.
- Deassertion of i_rst_n: requests are sampled from the next edge, so the earliest release is at edge STAGES+HOLD_CYCLES after i_rst_n goes high.
- Simultaneous events:
  - request and counter expiry in the same cycle: the request wins and the channel is not released;
  - i_rst_n low overrides everything.

## Configuration
- Macro: RST_SEQ_FILTER_EN.
- With the macro defined:
  - each channel has a saturating counter, and a req_s bit counts toward r_any only after it has been active FILTER_CYCLES consecutive cycles;
  - assertion latency grows by FILTER_CYCLES-1;
  - deassertion is unfiltered;
  - o_cause records filtered bits only.
- Without the macro, a single synced cycle of request triggers a sequence.

## Structure
- Package rst_seq_pkg holds:
  - the state encoding (ASSERT=2'd0, HOLD=2'd1, RELEASE=2'd2, DONE=2'd3);
  - the clog2 helper;
  - the STAGES clamp function.
- Sub-module bit_sync: one-bit STAGES-flop synchroniser with the ASYNC_REG/no-shreg attributes and a sync active-low reset value input. It is instantiated CHANNELS times.

## Test plan
All scenarios use the defaults (CHANNELS=4, STAGES=2, HOLD=16, STEP=4).
- Hold i_rst_n low for 5 cycles with i_req_n all ones, then release → o_rst=4'b1111 until edge 18. o_rst[0] falls at edge 18, [1] at 22, [2] at 26, [3] at 30. o_busy=0 from edge 30.
- In DONE, pulse i_req_n[2] low for 1 cycle → o_rst=4'b1111 after 2 edges, o_cause=4'b0100, then full re-release.
- Request i_req_n[1] during RELEASE just after o_rst[0] fell → all bits are high again two edges later, the sequence restarts, and o_cause holds bit 1.
- Request arriving in the same cycle the HOLD counter hits 0 → o_rst[0] stays high and the state is ASSERT.
- Drive i_rst_n low mid-RELEASE → the next edge gives o_rst=1111, o_cause=0, o_busy=1.
- With RST_SEQ_FILTER_EN, a 2-cycle pulse → no reaction. A 3-cycle pulse → assertion 2 cycles later than in the unfiltered build.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // ceil(log2(value)), never less than one bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int p = 1; p < value; p = p * 2) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int clamp_stages(input int stages);
    return (stages < 2) ? 2 : stages;
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// One-bit multi-flop synchroniser with a synchronous active-low reset to a chosen value.
module bit_sync
  import rst_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  localparam int N = clamp_stages(STAGES);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [N-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sync_q <= {N{i_rst_val}};
    else          sync_q <= {sync_q[N-2:0], i_d};
  end

  assign o_q = sync_q[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: merged requests assert all outputs, release is ordered from channel 0.
// Optional build macro RST_SEQ_FILTER_EN adds a per-channel minimum-assertion-length filter.
//
// state   | meaning
// ASSERT  | all outputs held, waiting for requests to go quiet
// HOLD    | quiet period counting down before channel 0 releases
// RELEASE | releasing channels 1..CHANNELS-1, one per step period
// DONE    | all channels released, watching for a new request
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STAGES        = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STEP_CYCLES   = 4,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_req_n,
  output logic [CHANNELS-1:0] o_rst,
  output logic                o_busy,
  output logic [CHANNELS-1:0] o_cause
);

  localparam int SYNC_STAGES = clamp_stages(STAGES);
  localparam int CNT_W = clog2_min1((HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES);
  localparam int IDX_W = clog2_min1(CHANNELS);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);

  logic [CHANNELS-1:0] req_s;
  logic [CHANNELS-1:0] req_f;
  logic                r_any;
  seq_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  // Synchronisers reset to "request active" so nothing releases until real inputs are seen.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_rst_val (1'b1),
      .i_d       (~i_req_n[c]),
      .o_q       (req_s[c])
    );
  end

`ifdef RST_SEQ_FILTER_EN
  localparam int FILT_W = clog2_min1(FILTER_CYCLES);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES - 1);

  logic [FILT_W-1:0] filt_cnt [CHANNELS];

  // Saturated at reset so the post-reset request window matches the unfiltered timing.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!i_rst_n)                   filt_cnt[c] <= FILT_MAX;
      else if (!req_s[c])             filt_cnt[c] <= '0;
      else if (filt_cnt[c] != FILT_MAX) filt_cnt[c] <= filt_cnt[c] + FILT_W'(1);
    end
  end

  always_comb begin
    req_f = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      req_f[c] = req_s[c] && (filt_cnt[c] == FILT_MAX);
    end
  end
`else
  // A filter length below one is illegal; such a build never reacts.
  assign req_f = req_s & {CHANNELS{(FILTER_CYCLES >= 1)}};
`endif

  assign r_any = |req_f;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      o_rst   <= '1;
      o_busy  <= 1'b1;
      o_cause <= '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          o_rst   <= '1;
          o_busy  <= 1'b1;
          idx     <= '0;
          o_cause <= o_cause | req_f;
          if (!r_any) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          o_cause <= o_cause | req_f;
          if (r_any) begin
            state <= ST_ASSERT;
          end else if (cnt == '0) begin
            o_rst[0] <= 1'b0;
            if (CHANNELS == 1) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
            end else begin
              state <= ST_RELEASE;
              idx   <= IDX_W'(1);
              cnt   <= STEP_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          o_cause <= o_cause | req_f;
          if (r_any) begin
            state <= ST_ASSERT;
            o_rst <= '1;
          end else if (cnt == '0) begin
            o_rst[idx] <= 1'b0;
            if (idx == LAST_IDX) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
              cnt <= STEP_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (r_any) begin
            state   <= ST_ASSERT;
            o_rst   <= '1;
            o_busy  <= 1'b1;
            o_cause <= req_f;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random requests against a quiet-run-length model.
module tb_reset_sequencer;

  localparam int CH    = 4;
  localparam int HOLD  = 16;
  localparam int STEP  = 4;
  localparam int FINAL = HOLD + 1 + (CH - 1) * STEP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] req_n;
  logic [CH-1:0] o_rst;
  logic          o_busy;
  logic [CH-1:0] o_cause;

  int checks = 0;
  int errors = 0;

  // Model: number of consecutive edges that saw no synced request; channel k is
  // released once that run reaches HOLD+1+k*STEP.
  int            run;
  logic [CH-1:0] cause_m;
  logic [CH-1:0] sync_m [2];

  reset_sequencer #(
    .CHANNELS(CH), .STAGES(2), .HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP), .FILTER_CYCLES(3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req_n (req_n),
    .o_rst   (o_rst),
    .o_busy  (o_busy),
    .o_cause (o_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_rst();
    logic [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = (run < HOLD + 1 + k * STEP);
    return v;
  endfunction

  task automatic model_update();
    logic [CH-1:0] rs;
    rs = sync_m[1];
    if (!rst_n) begin
      run = 0;
      cause_m = '0;
      sync_m[0] = '1;
      sync_m[1] = '1;
    end else begin
      if (|rs) begin
        cause_m = (run >= FINAL) ? rs : (cause_m | rs);
        run = 0;
      end else if (run < 100000) begin
        run++;
      end
      sync_m[1] = sync_m[0];
      sync_m[0] = ~req_n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_rst", o_rst, exp_rst());
    chk("model_busy", {3'b000, o_busy}, {3'b000, run < FINAL});
    chk("model_cause", o_cause, cause_m);
  endtask

  initial begin
    int n;
    run = 0;
    cause_m = '0;
    sync_m[0] = '1;
    sync_m[1] = '1;
    rst_n = 1'b0;
    req_n = '1;

    // Reset, then the nominal release schedule
    repeat (5) step();
    chk("reset_rst", o_rst, 4'b1111);
    chk("reset_cause", o_cause, 4'b0000);
    rst_n = 1'b1;
    for (int e = 0; e <= 31; e++) begin
      step();
      if (e == 17) chk("rel_e17", o_rst, 4'b1111);
      if (e == 18) chk("rel_e18", o_rst, 4'b1110);
      if (e == 21) chk("rel_e21", o_rst, 4'b1110);
      if (e == 22) chk("rel_e22", o_rst, 4'b1100);
      if (e == 26) chk("rel_e26", o_rst, 4'b1000);
      if (e == 29) chk("busy_e29", {3'b000, o_busy}, 4'b0001);
      if (e == 30) chk("rel_e30", o_rst, 4'b0000);
      if (e == 30) chk("busy_e30", {3'b000, o_busy}, 4'b0000);
    end

    // One-cycle request on channel 2 while DONE
    req_n = 4'b1011;
    for (int e = 0; e <= 31; e++) begin
      step();
      req_n = 4'b1111;
      if (e == 1) chk("done_req_e1", o_rst, 4'b0000);
      if (e == 2) chk("done_req_e2", o_rst, 4'b1111);
      if (e == 2) chk("done_cause", o_cause, 4'b0100);
      if (e == 30) chk("rerel_e30", o_rst, 4'b1000);
      if (e == 31) chk("rerel_e31", o_rst, 4'b0000);
    end

    // Request during RELEASE, right after channel 0 dropped
    req_n = 4'b1110;
    step();
    req_n = 4'b1111;
    n = 0;
    while (o_rst !== 4'b1110 && n < 40) begin step(); n++; end
    chk("wait_ch0", o_rst, 4'b1110);
    req_n = 4'b1101;
    step();
    req_n = 4'b1111;
    step();
    chk("rel_req_e1", o_rst, 4'b1110);
    step();
    chk("rel_req_e2", o_rst, 4'b1111);
    chk("rel_req_cause", o_cause, 4'b0011);
    n = 0;
    while (o_busy !== 1'b0 && n < 60) begin step(); n++; end
    chk("wait_done", {3'b000, o_busy}, 4'b0000);

    // Request lands on the edge where the hold counter expires
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      if (e == 16) req_n = 4'b0111;
      if (e == 17) req_n = 4'b1111;
      step();
      if (e == 17) chk("race_e17", o_rst, 4'b1111);
      if (e == 18) chk("race_e18", o_rst, 4'b1111);
      if (e == 19) chk("race_e19", o_rst, 4'b1111);
    end

    // Synchronous reset in the middle of RELEASE
    n = 0;
    while (o_rst !== 4'b1100 && n < 60) begin step(); n++; end
    chk("wait_ch1", o_rst, 4'b1100);
    rst_n = 1'b0;
    step();
    chk("midrst_rst", o_rst, 4'b1111);
    chk("midrst_cause", o_cause, 4'b0000);
    chk("midrst_busy", {3'b000, o_busy}, 4'b0001);
    rst_n = 1'b1;

    // Random requests and occasional resets
    for (int i = 0; i < 1500; i++) begin
      req_n = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
